// File: rtl/shift_add_mul.sv
// -----------------------------------------------------------------------------
// shift_add_mul
//
// Sequential unsigned multiplier using the classic shift-and-add scheme. Each
// accepted operation takes WIDTH EXEC cycles (one partial-product step per
// cycle) followed by one DONE cycle, during which op_done pulses and the
// product is already on result.
//
// Parameters
//   WIDTH         operand width; multiples of 4 from 4 to 16
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous active-high reset
//   op_start      begin a multiply (only honoured in IDLE)
//   op_clear      synchronous abort; returns to IDLE and zeroes result
//   multiplicand  operand A, captured when a start is accepted
//   multiplier    operand B, captured when a start is accepted
//   busy          high while the multiply is in progress (EXEC)
//   op_done       one-cycle pulse in DONE; result valid from this cycle
//   result        registered product A*B, held until next DONE/clear/reset
// -----------------------------------------------------------------------------
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W  = $clog2(WIDTH);
    localparam int GROUPS = WIDTH / 4;

    // One-hot encoding: busy and op_done are single state flops, so they are
    // glitch-free and can never be high together.
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        EXEC = 3'b010,
        DONE = 3'b100
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   q_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] result_reg;

    // ------------------------------------------------------------------
    // Adder: acc + (q[0] ? mcand : 0). Gating the addend makes the
    // "no add" case fall out of the same adder ({0,acc}).
    // Carry-lookahead within each 4-bit group, ripple between groups.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign add_b    = q_reg[0] ? mcand_reg : '0;
    assign gen      = acc_reg & add_b;
    assign prop     = acc_reg ^ add_b;
    assign carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
            localparam int B = 4 * gi;
            assign carry[B+1] = gen[B]
                              | (prop[B]   & carry[B]);
            assign carry[B+2] = gen[B+1]
                              | (prop[B+1] & gen[B])
                              | (prop[B+1] & prop[B]   & carry[B]);
            assign carry[B+3] = gen[B+2]
                              | (prop[B+2] & gen[B+1])
                              | (prop[B+2] & prop[B+1] & gen[B])
                              | (prop[B+2] & prop[B+1] & prop[B] & carry[B]);
            assign carry[B+4] = gen[B+3]
                              | (prop[B+3] & gen[B+2])
                              | (prop[B+3] & prop[B+2] & gen[B+1])
                              | (prop[B+3] & prop[B+2] & prop[B+1] & gen[B])
                              | (prop[B+3] & prop[B+2] & prop[B+1] & prop[B] & carry[B]);
        end
    endgenerate

    assign sum = prop ^ carry[WIDTH-1:0];

    // {acc,q} after this cycle's step: {c,s,q} >> 1, carry enters acc MSB.
    logic [2*WIDTH-1:0] shifted_next;
    assign shifted_next = {carry[WIDTH], sum, q_reg[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || op_clear) begin
            state_reg  <= IDLE;
            mcand_reg  <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (op_start) begin
                        mcand_reg <= multiplicand;
                        q_reg     <= multiplier;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    acc_reg <= shifted_next[2*WIDTH-1:WIDTH];
                    q_reg   <= shifted_next[WIDTH-1:0];
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                        // Capture the product including this final step so
                        // it is visible in the same cycle op_done is high.
                        result_reg <= shifted_next;
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = state_reg[1];
    assign op_done = state_reg[2];
    assign result  = result_reg;

endmodule

// File: tb/tb_shift_add_mul.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul
//
// Directed bench for shift_add_mul with WIDTH=8: a table of operand pairs with
// hand-computed products, each checked cycle by cycle for busy/op_done timing
// and result hold behaviour, plus hand-written sequences for ignored starts,
// op_clear abort, reset abort and back-to-back operation with op_start held.
// -----------------------------------------------------------------------------
module tb_shift_add_mul;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_start;
    logic           op_clear;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           op_done;
    logic [2*W-1:0] result;

    shift_add_mul #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;

    int             n_checks = 0;
    int             n_pass   = 0;
    logic [2*W-1:0] last_result;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Start one multiply and follow it to the cycle after DONE. The operands
    // are scrambled right after acceptance to show they are not re-sampled.
    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input string tag);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        @(negedge clk);
        op_start     = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check({tag, " exec busy/done"}, {30'd0, busy, op_done}, 32'b10);
            check({tag, " exec result hold"}, 32'(result), 32'(last_result));
            @(negedge clk);
        end
        check({tag, " done busy/done"}, {30'd0, busy, op_done}, 32'b01);
        check({tag, " product"}, 32'(result), 32'(exp));
        last_result = exp;
        @(negedge clk);
        check({tag, " idle busy/done"}, {30'd0, busy, op_done}, 32'b00);
        check({tag, " idle result hold"}, 32'(result), 32'(exp));
        $display("%s: %0d * %0d -> result=%04h (expected %04h)", tag, a, b, result, exp);
    endtask

    initial begin
        int done_cnt;

        vecs[0] = '{8'd13,  8'd11,  16'h008F};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01};
        vecs[2] = '{8'd0,   8'd200, 16'h0000};
        vecs[3] = '{8'd200, 8'd0,   16'h0000};
        vecs[4] = '{8'd1,   8'd1,   16'h0001};
        vecs[5] = '{8'd15,  8'd17,  16'h00FF};
        vecs[6] = '{8'd128, 8'd2,   16'h0100};
        vecs[7] = '{8'd170, 8'd85,  16'h3872};
        vecs[8] = '{8'd200, 8'd200, 16'h9C40};
        vecs[9] = '{8'd255, 8'd1,   16'h00FF};

        reset        = 1'b1;
        op_start     = 1'b1;   // must be overridden by reset
        op_clear     = 1'b0;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
        last_result  = '0;
        repeat (3) @(negedge clk);
        check("reset busy/done", {30'd0, busy, op_done}, 32'b00);
        check("reset result", 32'(result), 32'h0);
        reset    = 1'b0;
        op_start = 1'b0;
        $display("reset: busy=%0b op_done=%0b result=%04h", busy, op_done, result);

        // Table-driven products
        for (int i = 0; i < 10; i++) begin
            run_mul(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
        end

        // Start pulses during EXEC and DONE are ignored
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd9;
        op_start     = 1'b1;
        @(negedge clk);                         // EXEC cycle 1
        op_start = 1'b0;
        for (int i = 1; i <= W; i++) begin
            check("ignore exec busy/done", {30'd0, busy, op_done}, 32'b10);
            if (i == 3) begin
                multiplicand = 8'd2;
                multiplier   = 8'd2;
                op_start     = 1'b1;
            end else begin
                op_start = 1'b0;
            end
            @(negedge clk);
        end
        check("ignore done busy/done", {30'd0, busy, op_done}, 32'b01);
        check("ignore product", 32'(result), 32'h003F);
        op_start = 1'b1;                        // start seen in DONE: dropped
        @(negedge clk);
        op_start = 1'b0;
        @(negedge clk);
        check("start in done dropped", {30'd0, busy, op_done}, 32'b00);
        check("ignore result hold", 32'(result), 32'h003F);
        last_result = 16'h003F;
        $display("ignore-start: 7 * 9 -> result=%04h", result);

        // op_clear mid-EXEC; a simultaneous start is ignored
        @(negedge clk);
        multiplicand = 8'd100;
        multiplier   = 8'd3;
        op_start     = 1'b1;
        @(negedge clk);                         // EXEC cycle 1
        op_start = 1'b0;
        repeat (3) @(negedge clk);              // EXEC cycle 4
        check("pre-clear busy", {31'd0, busy}, 32'd1);
        op_clear = 1'b1;
        op_start = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        op_start = 1'b0;
        check("clear busy/done", {30'd0, busy, op_done}, 32'b00);
        check("clear result", 32'(result), 32'h0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (op_done || busy) done_cnt++;
        end
        check("clear no activity", 32'(done_cnt), 32'd0);
        last_result = '0;
        $display("clear: busy=%0b result=%04h", busy, result);
        run_mul(8'd5, 8'd6, 16'h001E, "post-clear");

        // Reset mid-EXEC after a result of 0x008F
        run_mul(8'd13, 8'd11, 16'h008F, "pre-reset");
        @(negedge clk);
        multiplicand = 8'd7;
        multiplier   = 8'd7;
        op_start     = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        repeat (2) @(negedge clk);              // EXEC cycle 3
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset-exec busy/done", {30'd0, busy, op_done}, 32'b00);
        check("reset-exec result", 32'(result), 32'h0);
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (op_done) done_cnt++;
        end
        check("reset-exec no done", 32'(done_cnt), 32'd0);
        last_result = '0;
        $display("reset-mid-exec: busy=%0b result=%04h", busy, result);
        run_mul(8'd13, 8'd11, 16'h008F, "post-reset");

        // op_start held for 30 cycles: op_done every W+2 cycles
        @(negedge clk);
        multiplicand = 8'd3;
        multiplier   = 8'd4;
        op_start     = 1'b1;
        done_cnt     = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                check("held done pulse", {31'd0, op_done}, 32'd1);
                check("held product", 32'(result), 32'h000C);
            end else begin
                check("held no done", {31'd0, op_done}, 32'd0);
            end
            if (op_done) done_cnt++;
        end
        op_start = 1'b0;
        check("held done count", 32'(done_cnt), 32'd3);
        $display("held-start: %0d done pulses, result=%04h", done_cnt, result);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: WIDTH, default 8, operand width; legal values are multiples of 4 from 4 to 16.
REQ-002 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: op_start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: op_clear  input  1  synchronous abort and result clear.
REQ-006 Port: multiplicand  input  WIDTH  operand A, unsigned; captured on start acceptance.
REQ-007 Port: multiplier  input  WIDTH  operand B, unsigned; captured on start acceptance.
REQ-008 Port: busy  output  1  high while in EXEC.
REQ-009 Port: op_done  output  1  one-cycle pulse while in DONE; result valid from this cycle.
REQ-010 Port: result  output  2*WIDTH  registered unsigned product A*B.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, EXEC, DONE; encoding is free.
REQ-012 Datapath: mcand reg (WIDTH), acc reg (WIDTH, upper half), q reg (WIDTH, lower half), cnt reg (ceil(log2(WIDTH)) bits).
REQ-013 Adder: one WIDTH-bit carry-lookahead adder (4-bit lookahead groups, ripple between groups), carry-in 0; sole adder in the block.
REQ-014 IDLE, op_start=1 at an edge -> mcand<=A, q<=B, acc<=0, cnt<=0, next state EXEC.
REQ-015 EXEC, per edge: if q[0]=1, {c,s} = acc + mcand; else {c,s} = {0,acc}; then {acc,q} <= {c,s,q} >> 1 (c enters acc MSB).
REQ-016 EXEC lasts exactly WIDTH cycles (cnt 0..WIDTH-1); at cnt=WIDTH-1 the next state is DONE.
REQ-017 DONE: result <= {acc,q} on entry edge, so result is valid in the same cycle op_done=1; next state is IDLE unconditionally.
REQ-018 Latency: op_start sampled at edge k -> busy high k+1..k+WIDTH, op_done high in cycle k+WIDTH+1, IDLE at k+WIDTH+2.
REQ-019 result SHALL hold its value from DONE until the next DONE, op_clear, or reset; it never shows intermediate products.
REQ-020 op_start in EXEC or DONE SHALL be ignored, with no queuing; a new start is accepted in IDLE only.
REQ-021 op_start held continuously SHALL start a new operation on every IDLE cycle, giving a period of WIDTH+2 cycles.
REQ-022 Operand inputs SHALL be don't-care except at the acceptance edge; changes during EXEC do not affect result.
REQ-023 op_clear=1 at any edge -> state IDLE, result<=0, acc/q/cnt<=0, no op_done; op_start on the same edge is ignored.
REQ-024 Priority: reset > op_clear > op_start.
REQ-025 busy and op_done SHALL be decoded from the state register only, are never simultaneously high, and are glitch-free registered outputs.
REQ-026 Boundary: A=0 or B=0 yields result 0 with full WIDTH+2 latency (no early termination); carry out of the adder is never lost.

Reset
REQ-027 reset=1 at an edge -> state IDLE, busy=0, op_done=0, result=0, and all datapath registers 0, regardless of state.
REQ-028 Reset asserted mid-EXEC SHALL abort with no op_done pulse; the first start after reset deassertion behaves per REQ-018.
REQ-029 No output SHALL depend combinationally on reset.

Verification
REQ-030 WIDTH=8: A=13, B=11, start pulse at edge k -> busy k+1..k+8, op_done only at k+9, result=16'h008F.
REQ-031 A=255, B=255 -> result=16'hFE01 (carry path exercised); then A=0, B=200 -> result=16'h0000 after 9 cycles.
REQ-032 Start A=7, B=9; at EXEC cycle 3 pulse op_start with A=2, B=2 -> ignored, result=16'h003F.
REQ-033 Start A=100, B=3; op_clear at EXEC cycle 4 -> IDLE next cycle, result=0, no op_done; next start with A=5, B=6 -> result=16'h001E.
REQ-034 reset mid-EXEC after a prior result of 16'h008F -> result=0, busy=0, no op_done pulse.
REQ-035 op_start held high for 30 cycles with A=3, B=4 -> op_done every 10 cycles, result=16'h000C each time.
